// File: rtl/defuse_stage_engine_if.sv
// Player-facing signal bundle for defuse_stage_engine.
// The master side drives the button, switches and enable; the slave side is the engine.
interface defuse_stage_engine_if #(
    parameter int SW_WIDTH = 4
);
    localparam int TW = $clog2(SW_WIDTH);

    logic                start_btn_press;
    logic [SW_WIDTH-1:0] switch;
    logic                game_enable;
    logic [TW-1:0]       target;
    logic [3:0]          stage;
    logic [7:0]          score;
    logic [2:0]          strikes;
    logic                stage_done;
    logic                game_complete;
    logic                game_lost;

    modport master (
        output start_btn_press, switch, game_enable,
        input  target, stage, score, strikes, stage_done, game_complete, game_lost
    );

    modport slave (
        input  start_btn_press, switch, game_enable,
        output target, stage, score, strikes, stage_done, game_complete, game_lost
    );
endinterface

// File: rtl/defuse_stage_engine.sv
// Multi-stage "defuse" game: each stage picks a random switch and the player must press
// with exactly that switch set before the per-attempt timer expires.
module defuse_stage_engine #(
    parameter int          NUM_STAGES     = 4,
    parameter int          SW_WIDTH       = 4,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          MAX_STRIKES    = 3,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input logic                  clk,
    input logic                  rst,
    defuse_stage_engine_if.slave bus
);
    localparam int TW  = $clog2(SW_WIDTH);
    localparam int TMW = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_LOSE  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                btn_q, primed_q;
    logic [SW_WIDTH-1:0] sw_q, sw_d;
    logic [TMW-1:0]      timer_q, timer_d;
    logic [TW-1:0]       target_q, target_d;
    logic [3:0]          stage_q, stage_d;
    logic [7:0]          score_q, score_d;
    logic [2:0]          strikes_q, strikes_d;
    logic                stage_done_q, stage_done_d;
    logic                complete_q, complete_d;
    logic                lost_q, lost_d;

    logic                btn_edge;
    logic [SW_WIDTH-1:0] onehot;
    logic [8:0]          score_sum;
    logic [2:0]          strikes_inc;

    // primed_q masks the first cycle after reset so a button held through reset is not an edge
    assign btn_edge    = bus.start_btn_press & ~btn_q & primed_q;
    assign onehot      = {{(SW_WIDTH-1){1'b0}}, 1'b1} << target_q;
    assign score_sum   = {1'b0, score_q} + {5'd0, stage_q} + 9'd1;
    assign strikes_inc = strikes_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        sw_d         = sw_q;
        timer_d      = timer_q;
        target_d     = target_q;
        stage_d      = stage_q;
        score_d      = score_q;
        strikes_d    = strikes_q;
        stage_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_edge) begin
                    score_d   = '0;
                    stage_d   = '0;
                    strikes_d = '0;
                    state_d   = S_GEN;
                end
            end
            S_GEN: begin
                target_d = lfsr_q[TW-1:0];
                timer_d  = '0;
                state_d  = S_ARMED;
            end
            S_ARMED: begin
                if (btn_edge) begin
                    sw_d    = bus.switch;
                    state_d = S_CHECK;
                end else if (timer_q == TMW'(TIMEOUT_CYCLES - 1)) begin
                    timer_d   = '0;
                    strikes_d = strikes_inc;
                    if (strikes_inc == 3'(MAX_STRIKES))
                        state_d = S_LOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (sw_q == onehot) begin
                    score_d      = score_sum[8] ? 8'hFF : score_sum[7:0];
                    stage_done_d = 1'b1;
                    if (stage_q == 4'(NUM_STAGES - 1)) begin
                        state_d = S_WIN;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        state_d = S_GEN;
                    end
                end else begin
                    strikes_d = strikes_inc;
                    timer_d   = '0;
                    state_d   = (strikes_inc == 3'(MAX_STRIKES)) ? S_LOSE : S_ARMED;
                end
            end
            S_WIN, S_LOSE: begin
                if (btn_edge)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!bus.game_enable) begin
            state_d      = S_IDLE;
            stage_d      = '0;
            strikes_d    = '0;
            stage_done_d = 1'b0;
        end

        complete_d = (state_d == S_WIN) || (state_d == S_LOSE);
        lost_d     = (state_d == S_LOSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            btn_q        <= 1'b0;
            primed_q     <= 1'b0;
            sw_q         <= '0;
            timer_q      <= '0;
            target_q     <= '0;
            stage_q      <= '0;
            score_q      <= '0;
            strikes_q    <= '0;
            stage_done_q <= 1'b0;
            complete_q   <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            btn_q        <= bus.start_btn_press;
            primed_q     <= 1'b1;
            sw_q         <= sw_d;
            timer_q      <= timer_d;
            target_q     <= target_d;
            stage_q      <= stage_d;
            score_q      <= score_d;
            strikes_q    <= strikes_d;
            stage_done_q <= stage_done_d;
            complete_q   <= complete_d;
            lost_q       <= lost_d;
        end
    end

    assign bus.target        = target_q;
    assign bus.stage         = stage_q;
    assign bus.score         = score_q;
    assign bus.strikes       = strikes_q;
    assign bus.stage_done    = stage_done_q;
    assign bus.game_complete = complete_q;
    assign bus.game_lost     = lost_q;
endmodule

// File: tb/tb_defuse_stage_engine.sv
// Directed bench for defuse_stage_engine: default instance plus an 8-switch single-stage instance.
module tb_defuse_stage_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    defuse_stage_engine_if #(.SW_WIDTH(4)) ba ();
    defuse_stage_engine_if #(.SW_WIDTH(8)) bb ();

    defuse_stage_engine #(
        .NUM_STAGES(4), .SW_WIDTH(4), .TIMEOUT_CYCLES(1000), .MAX_STRIKES(3), .SEED(16'hACE1)
    ) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));

    defuse_stage_engine #(
        .NUM_STAGES(1), .SW_WIDTH(8), .TIMEOUT_CYCLES(1000), .MAX_STRIKES(3), .SEED(16'hACE1)
    ) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

    // Reference LFSR written in the shift/xor arithmetic form of the 16,14,13,11 polynomial
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) |
                           (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit which);
        @(negedge clk);
        if (which) bb.start_btn_press = 1'b1; else ba.start_btn_press = 1'b1;
        @(negedge clk);
        if (which) bb.start_btn_press = 1'b0; else ba.start_btn_press = 1'b0;
    endtask

    logic [2:0] exp_t;
    logic [3:0] sw4;
    logic [7:0] exp_score;

    initial begin
        ba.start_btn_press = 1'b0; ba.switch = '0; ba.game_enable = 1'b1;
        bb.start_btn_press = 1'b0; bb.switch = '0; bb.game_enable = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        check_eq("rst_target",   16'(ba.target), 16'd0);
        check_eq("rst_stage",    16'(ba.stage), 16'd0);
        check_eq("rst_score",    16'(ba.score), 16'd0);
        check_eq("rst_strikes",  16'(ba.strikes), 16'd0);
        check_eq("rst_done",     16'(ba.stage_done), 16'd0);
        check_eq("rst_complete", 16'(ba.game_complete), 16'd0);
        check_eq("rst_lost",     16'(ba.game_lost), 16'd0);

        // Win path through four stages
        press(0);
        exp_t = {1'b0, m_lfsr[1:0]};
        step(1);
        exp_score = 8'd0;
        for (int s = 0; s < 4; s++) begin
            check_eq($sformatf("win_target%0d", s), 16'(ba.target), 16'(exp_t[1:0]));
            sw4 = 4'd1 << exp_t[1:0];
            ba.switch = sw4;
            press(0);
            step(1);
            exp_score = exp_score + 8'(s + 1);
            check_eq($sformatf("win_done%0d", s), 16'(ba.stage_done), 16'd1);
            check_eq($sformatf("win_score%0d", s), 16'(ba.score), 16'(exp_score));
            exp_t = {1'b0, m_lfsr[1:0]};
            step(1);
            check_eq($sformatf("win_pulse%0d", s), 16'(ba.stage_done), 16'd0);
            check_eq($sformatf("win_stage%0d", s), 16'(ba.stage), 16'(s < 3 ? s + 1 : 3));
        end
        check_eq("win_score", 16'(ba.score), 16'd10);
        check_eq("win_complete", 16'(ba.game_complete), 16'd1);
        check_eq("win_lost", 16'(ba.game_lost), 16'd0);

        // WIN -> IDLE keeps score; new game clears it
        press(0);
        check_eq("idle_score_held", 16'(ba.score), 16'd10);
        check_eq("idle_complete", 16'(ba.game_complete), 16'd0);
        press(0);
        exp_t = {1'b0, m_lfsr[1:0]};
        step(1);
        check_eq("new_score", 16'(ba.score), 16'd0);
        check_eq("new_target", 16'(ba.target), 16'(exp_t[1:0]));

        // Wrong answer (all bits but the right one)
        sw4 = ~(4'd1 << exp_t[1:0]);
        ba.switch = sw4;
        press(0);
        step(1);
        check_eq("wrong_strikes", 16'(ba.strikes), 16'd1);
        check_eq("wrong_done", 16'(ba.stage_done), 16'd0);
        check_eq("wrong_score", 16'(ba.score), 16'd0);
        check_eq("wrong_target", 16'(ba.target), 16'(exp_t[1:0]));
        sw4 = 4'd1 << exp_t[1:0];
        ba.switch = sw4;
        press(0);
        step(1);
        check_eq("retry_done", 16'(ba.stage_done), 16'd1);
        check_eq("retry_score", 16'(ba.score), 16'd1);
        exp_t = {1'b0, m_lfsr[1:0]};
        step(1);
        check_eq("s1_target", 16'(ba.target), 16'(exp_t[1:0]));

        // Correct press lands on the exact timeout edge
        sw4 = 4'd1 << exp_t[1:0];
        ba.switch = sw4;
        step(998);
        press(0);
        step(1);
        check_eq("sim_done", 16'(ba.stage_done), 16'd1);
        check_eq("sim_strikes", 16'(ba.strikes), 16'd1);
        check_eq("sim_score", 16'(ba.score), 16'd3);
        check_eq("sim_stage", 16'(ba.stage), 16'd2);

        // Reset mid-game with the button held through release
        ba.start_btn_press = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        check_eq("mrst_stage", 16'(ba.stage), 16'd0);
        check_eq("mrst_score", 16'(ba.score), 16'd0);
        check_eq("mrst_strikes", 16'(ba.strikes), 16'd0);
        check_eq("mrst_target", 16'(ba.target), 16'd0);
        check_eq("mrst_complete", 16'(ba.game_complete), 16'd0);
        ba.start_btn_press = 1'b0;
        step(1100);
        check_eq("held_no_start", 16'(ba.strikes), 16'd0);

        // Loss by three timeouts
        press(0);
        step(1);
        step(999);
        check_eq("to_pre1", 16'(ba.strikes), 16'd0);
        step(1);
        check_eq("to_strike1", 16'(ba.strikes), 16'd1);
        step(999);
        check_eq("to_pre2", 16'(ba.strikes), 16'd1);
        step(1);
        check_eq("to_strike2", 16'(ba.strikes), 16'd2);
        step(999);
        check_eq("to_pre3_lost", 16'(ba.game_lost), 16'd0);
        step(1);
        check_eq("to_strike3", 16'(ba.strikes), 16'd3);
        check_eq("to_lost", 16'(ba.game_lost), 16'd1);
        check_eq("to_complete", 16'(ba.game_complete), 16'd1);

        // game_enable low forces IDLE
        ba.game_enable = 1'b0;
        step(1);
        check_eq("en_strikes", 16'(ba.strikes), 16'd0);
        check_eq("en_lost", 16'(ba.game_lost), 16'd0);
        check_eq("en_complete", 16'(ba.game_complete), 16'd0);
        ba.game_enable = 1'b1;

        // Single-stage, 8-switch instance
        press(1);
        exp_t = m_lfsr[2:0];
        step(1);
        check_eq("sw8_target", 16'(bb.target), 16'(exp_t));
        bb.switch = 8'd1 << exp_t;
        press(1);
        step(1);
        check_eq("sw8_done", 16'(bb.stage_done), 16'd1);
        check_eq("sw8_score", 16'(bb.score), 16'd1);
        check_eq("sw8_complete", 16'(bb.game_complete), 16'd1);
        check_eq("sw8_lost", 16'(bb.game_lost), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
